// File: rtl/univ_shift_reg_nres.sv
// Universal shift register with an automatic multi-bit shift sequencer.
// All state changes on the falling edge of clk. n_res is a synchronous,
// active-low reset sampled on that same edge.
//
// state | meaning
// IDLE  | manual operation; a start with a shift mode begins a sequence
// RUN   | applying run_mode once per enabled edge until cnt reaches zero
module univ_shift_reg_nres #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             n_res,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ser_in,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] M_HOLD  = 3'd0;
  localparam logic [2:0] M_LOAD  = 3'd1;
  localparam logic [2:0] M_SHL   = 3'd2;
  localparam logic [2:0] M_SHR   = 3'd3;
  localparam logic [2:0] M_ROL   = 3'd4;
  localparam logic [2:0] M_ROR   = 3'd5;
  localparam logic [2:0] M_ASR   = 3'd6;
  localparam logic [2:0] M_CLEAR = 3'd7;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_reg, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       run_mode_q, run_mode_d;
  logic             done_q, done_d;
  logic             is_shift;
  logic [2:0]       active_mode;

  // One register update for the given operation
  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       m,
                                                input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] d,
                                                input logic             s);
    logic [WIDTH-1:0] r;
    r = v;
    case (m)
      M_HOLD:  r = v;
      M_LOAD:  r = d;
      M_SHL:   r = {v[WIDTH-2:0], s};
      M_SHR:   r = {s, v[WIDTH-1:1]};
      M_ROL:   r = {v[WIDTH-2:0], v[WIDTH-1]};
      M_ROR:   r = {v[0], v[WIDTH-1:1]};
      M_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
      M_CLEAR: r = '0;
      default: r = v;
    endcase
    return r;
  endfunction

  assign is_shift = (mode >= M_SHL) && (mode <= M_ASR);

  // Next-state, register data, counter and done-pulse logic
  always_comb begin
    state_d    = state_q;
    q_d        = q_reg;
    cnt_d      = cnt_q;
    run_mode_d = run_mode_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          if (start && is_shift) begin
            if (amount == '0) begin
              done_d = 1'b1;
            end else begin
              state_d    = RUN;
              cnt_d      = amount;
              run_mode_d = mode;
            end
          end else begin
            q_d = apply_op(mode, q_reg, d_in, ser_in);
          end
        end
      end
      RUN: begin
        if (en) begin
          q_d   = apply_op(run_mode_q, q_reg, d_in, ser_in);
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Falling-edge state register with synchronous active-low reset
  always_ff @(negedge clk) begin
    if (!n_res) begin
      state_q    <= IDLE;
      q_reg      <= '0;
      cnt_q      <= '0;
      run_mode_q <= M_HOLD;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_reg      <= q_d;
      cnt_q      <= cnt_d;
      run_mode_q <= run_mode_d;
      done_q     <= done_d;
    end
  end

  // The bit the active shift direction would expel next
  always_comb begin
    active_mode = (state_q == RUN) ? run_mode_q : mode;
    ser_out     = ((active_mode == M_SHL) || (active_mode == M_ROL)) ?
                  q_reg[WIDTH-1] : q_reg[0];
  end

  assign q_out = q_reg;
  assign busy  = (state_q == RUN);
  assign done  = done_q;

endmodule

// File: tb/tb_univ_shift_reg_nres.sv
// Scoreboard bench for univ_shift_reg_nres: the driver computes each
// expected post-edge response from a behavioural model and queues it; a
// monitor pops and compares after every falling edge.
module tb_univ_shift_reg_nres;

  localparam int W     = 8;
  localparam int CW    = $clog2(W + 1);
  localparam int MASK  = (1 << W) - 1;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                         ROL = 3'd4, ROR = 3'd5, ASR = 3'd6, CLR = 3'd7;

  logic          clk;
  logic          n_res, en, ser_in, start;
  logic [2:0]    mode;
  logic [W-1:0]  d_in;
  logic [CW-1:0] amount;
  logic [W-1:0]  q_out;
  logic          ser_out, busy, done;

  univ_shift_reg_nres #(.WIDTH(W)) dut (
    .clk(clk), .n_res(n_res), .en(en), .mode(mode), .d_in(d_in),
    .ser_in(ser_in), .start(start), .amount(amount),
    .q_out(q_out), .ser_out(ser_out), .busy(busy), .done(done)
  );

  typedef struct {
    int unsigned q;
    bit          busy;
    bit          done;
    bit          ser;
  } resp_t;

  resp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int unsigned m_q     = 0;
  bit          m_busy  = 0;
  int          m_left  = 0;
  int unsigned m_rmode = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned op(int unsigned m, int unsigned v,
                                     int unsigned d, int unsigned s);
    case (m)
      1: return d & MASK;
      2: return ((v * 2) + s) & MASK;
      3: return (v / 2) + s * (1 << (W - 1));
      4: return ((v * 2) + (v / (1 << (W - 1)))) & MASK;
      5: return (v / 2) + (v % 2) * (1 << (W - 1));
      6: return (v / 2) + (v & (1 << (W - 1)));
      7: return 0;
      default: return v;
    endcase
  endfunction

  task automatic chk(string name, int unsigned act, int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle on the rising edge and queue the expected response
  task automatic step(bit nr, bit e, logic [2:0] m, int unsigned d,
                      bit s, bit st, int unsigned amt);
    resp_t r;
    int unsigned am;
    @(posedge clk);
    n_res = nr; en = e; mode = m; d_in = W'(d); ser_in = s;
    start = st; amount = CW'(amt);
    r.done = 0;
    if (!nr) begin
      m_q = 0; m_busy = 0; m_left = 0;
    end else if (m_busy) begin
      if (e) begin
        m_q = op(m_rmode, m_q, d, s);
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          r.done = 1;
        end
      end
    end else if (e) begin
      if (st && m >= 2 && m <= 6) begin
        if (amt == 0) r.done = 1;
        else begin
          m_busy = 1; m_left = amt; m_rmode = m;
        end
      end else begin
        m_q = op(m, m_q, d, s);
      end
    end
    am     = m_busy ? m_rmode : m;
    r.q    = m_q;
    r.busy = m_busy;
    r.ser  = (am == 2 || am == 4) ? ((m_q >> (W - 1)) & 1) : (m_q & 1);
    sb.push_back(r);
  endtask

  task automatic after_edge();
    @(negedge clk);
    #2;
  endtask

  // Monitor: compare every post-edge response against the queued one
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (q_out !== W'(e.q) || busy !== e.busy || done !== e.done ||
            ser_out !== e.ser) begin
          bad++;
          $display("FAIL scoreboard t=%0t: got q=%h busy=%b done=%b ser=%b expected q=%h busy=%b done=%b ser=%b",
                   $time, q_out, busy, done, ser_out, W'(e.q), e.busy, e.done, e.ser);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    n_res = 0; en = 0; mode = HOLD; d_in = '0; ser_in = 0; start = 0; amount = '0;

    // Reset with a load pending
    step(0, 1, LOAD, 'hFF, 0, 0, 0);
    step(0, 1, LOAD, 'hFF, 0, 0, 0);
    after_edge();
    chk("reset_q", q_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ser", ser_out, 0);

    // Manual operations
    step(1, 1, LOAD, 'hA5, 0, 0, 0);
    step(1, 1, SHL, 0, 1, 0, 0);
    after_edge(); chk("shl_q", q_out, 'h4B);
    step(1, 1, SHR, 0, 0, 0, 0);
    after_edge(); chk("shr_q", q_out, 'h25);
    step(1, 1, LOAD, 'h80, 0, 0, 0);
    step(1, 1, ASR, 0, 0, 0, 0);
    after_edge(); chk("asr_q", q_out, 'hC0);
    step(1, 0, LOAD, 'h33, 0, 0, 0);
    after_edge(); chk("en0_hold", q_out, 'hC0);
    step(1, 1, CLR, 0, 0, 0, 0);
    after_edge(); chk("clear_q", q_out, 0);

    // Automatic rotate left by 3
    step(1, 1, LOAD, 'h81, 0, 0, 0);
    step(1, 1, ROL, 0, 0, 1, 3);
    after_edge(); chk("rol_start_busy", busy, 1);
    step(1, 1, HOLD, 0, 0, 0, 0);
    after_edge(); chk("rol_1", q_out, 'h03);
    step(1, 1, HOLD, 0, 0, 0, 0);
    after_edge(); chk("rol_2", q_out, 'h06);
    step(1, 1, HOLD, 0, 0, 0, 0);
    after_edge();
    chk("rol_3", q_out, 'h0C);
    chk("rol_done", done, 1);
    chk("rol_busy_end", busy, 0);
    step(1, 1, HOLD, 0, 0, 0, 0);
    after_edge(); chk("rol_done_clear", done, 0);

    // Stalled SHR sequence with ignored inputs while stalled
    step(1, 1, LOAD, 'hF0, 0, 0, 0);
    step(1, 1, SHR, 0, 0, 1, 4);
    step(1, 1, HOLD, 0, 0, 0, 0);
    step(1, 1, LOAD, 'h12, 0, 1, 7);
    step(1, 0, LOAD, 'h55, 0, 1, 2);
    step(1, 0, CLR, 'hAA, 0, 0, 2);
    after_edge(); chk("stall_busy", busy, 1);
    step(1, 1, ROL, 'h99, 0, 1, 1);
    step(1, 1, HOLD, 0, 0, 0, 0);
    after_edge();
    chk("stall_final", q_out, 'h0F);
    chk("stall_done", done, 1);

    // Edge cases
    step(1, 1, SHL, 0, 1, 1, 0);
    after_edge();
    chk("amt0_done", done, 1);
    chk("amt0_q", q_out, 'h0F);
    chk("amt0_busy", busy, 0);
    step(1, 1, LOAD, 'h5A, 0, 1, 3);
    after_edge();
    chk("start_load_q", q_out, 'h5A);
    chk("start_load_busy", busy, 0);
    chk("start_load_done", done, 0);

    // Reset in the middle of a sequence, then a fresh sequence
    step(1, 1, LOAD, 'h3C, 0, 0, 0);
    step(1, 1, ROR, 0, 0, 1, 5);
    step(1, 1, HOLD, 0, 0, 0, 0);
    step(0, 1, HOLD, 0, 0, 0, 0);
    after_edge();
    chk("abort_q", q_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    step(1, 1, LOAD, 'h11, 0, 0, 0);
    step(1, 1, ROL, 0, 0, 1, 2);
    step(1, 1, HOLD, 0, 0, 0, 0);
    step(1, 1, HOLD, 0, 0, 0, 0);
    after_edge();
    chk("restart_q", q_out, 'h44);
    chk("restart_done", done, 1);

    // Randomized traffic, including amounts beyond WIDTH
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 39) != 0, $urandom_range(0, 4) != 0,
           3'($urandom_range(0, 7)), $urandom_range(0, MASK),
           1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
           $urandom_range(0, (1 << CW) - 1));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #3;
    chk("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
